branch_resolve_unit: RTL and testbench



---
 rtl/branch_resolve_unit_pkg.sv | 13 +
 rtl/branch_resolve_unit_if.sv | 39 +++
 rtl/branch_resolve_unit_bht.sv | 31 +++
 rtl/branch_resolve_unit.sv | 92 +++++++++
 tb/tb_branch_resolve_unit.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared opcodes, branch funct3 encodings and FSM states
package branch_resolve_unit_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: fetch, EX and redirect signals of the branch unit
// master: pipeline side (drives fetch_pc, ex_*); slave: the branch unit.
// BRU_PERF_EN adds perf_branches / perf_mispredicts.
interface branch_resolve_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic            bru_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_alu_out;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal_br;
`ifdef BRU_PERF_EN
  logic [31:0]     perf_branches;
  logic [31:0]     perf_mispredicts;
  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_alu_out, ex_target, ex_pred_taken,
    input  pred_taken, bru_ready, redirect, redirect_pc, illegal_br, perf_branches, perf_mispredicts
  );
  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_alu_out, ex_target, ex_pred_taken,
    output pred_taken, bru_ready, redirect, redirect_pc, illegal_br, perf_branches, perf_mispredicts
  );
`else
  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_alu_out, ex_target, ex_pred_taken,
    input  pred_taken, bru_ready, redirect, redirect_pc, illegal_br
  );
  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_opcode, ex_funct3, ex_alu_out, ex_target, ex_pred_taken,
    output pred_taken, bru_ready, redirect, redirect_pc, illegal_br
  );
`endif
endinterface

// File: rtl/branch_resolve_unit_bht.sv
// bht_table: bimodal saturating-counter array, async read, sync update/init write
// rd_idx_i/rd_msb_o: fetch prediction port (old value on same-edge write)
// init_i/init_idx_i: writes weakly-not-taken into one entry
// upd_i/upd_idx_i/upd_taken_i: saturating increment/decrement of one entry
module bht_table #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int IW       = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic [IW-1:0] rd_idx_i,
  output logic          rd_msb_o,
  input  logic          init_i,
  input  logic [IW-1:0] init_idx_i,
  input  logic          upd_i,
  input  logic [IW-1:0] upd_idx_i,
  input  logic          upd_taken_i
);
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] cur, ctr_d;
  always_comb begin
    cur   = ctr_q[upd_idx_i];
    ctr_d = upd_taken_i ? ((&cur) ? cur : cur + CTR_BITS'(1)) : ((|cur) ? cur - CTR_BITS'(1) : cur);
  end
  always_ff @(posedge clk) begin
    if (init_i) ctr_q[init_idx_i] <= WEAK_NT;
    else if (upd_i) ctr_q[upd_idx_i] <= ctr_d;
  end
  assign rd_msb_o = ctr_q[rd_idx_i][CTR_BITS-1];
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches/jumps, trains a bimodal BHT, registers redirects
// clk, rst: clock, synchronous active-high reset
// bus (slave): fetch_pc/pred_taken, ex_* resolution inputs, redirect/redirect_pc/illegal_br, bru_ready
// Optional macro BRU_PERF_EN: saturating perf_branches / perf_mispredicts counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_unit_if.slave bus
);
  localparam int IW = $clog2(BHT_ENTRIES);
  state_e          state_q, state_d;
  logic [IW-1:0]   init_idx_q, init_idx_d;
  logic            redirect_q, redirect_d, illegal_q, illegal_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            run, act, is_br, is_jal, is_jalr, bad_f3, br_taken, ctrl, taken, mispredict, rd_msb;
  logic [XLEN-1:0] tgt, next_pc;
  logic            unused;
  assign unused = ^{bus.fetch_pc[XLEN-1:IW+2], bus.fetch_pc[1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_idx_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_idx_q    <= init_idx_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
    end
  end
  always_comb begin
    run        = state_q == ST_RUN;
    init_idx_d = run ? init_idx_q : init_idx_q + IW'(1);
    state_d    = (!run && init_idx_q == IW'(BHT_ENTRIES - 1)) ? ST_RUN : state_q;
    // A valid EX slot during a redirect pulse is wrong-path and must not act.
    act        = run && bus.ex_valid && !redirect_q;
    is_br      = bus.ex_opcode == OP_BRANCH;
    is_jal     = bus.ex_opcode == OP_JAL;
    is_jalr    = bus.ex_opcode == OP_JALR;
    bad_f3     = bus.ex_funct3[2:1] == 2'b01;
    br_taken   = (bus.ex_funct3 == F3_BEQ) ? bus.ex_alu_out == '0 :
                 (bus.ex_funct3 == F3_BNE) ? bus.ex_alu_out != '0 :
                 (bus.ex_funct3 == F3_BLT || bus.ex_funct3 == F3_BLTU) ? bus.ex_alu_out[0] :
                 (bus.ex_funct3 == F3_BGE || bus.ex_funct3 == F3_BGEU) ? !bus.ex_alu_out[0] : 1'b0;
    ctrl       = (is_br && !bad_f3) || is_jal || is_jalr;
    taken      = is_jal || is_jalr || (is_br && br_taken);
    tgt        = is_jalr ? {bus.ex_target[XLEN-1:1], 1'b0} : bus.ex_target;
    next_pc    = taken ? tgt : bus.ex_pc + XLEN'(4);
    mispredict = act && ctrl && (taken != bus.ex_pred_taken);
    redirect_d    = mispredict;
    redirect_pc_d = mispredict ? next_pc : redirect_pc_q;
    illegal_d     = act && is_br && bad_f3;
  end
  bht_table #(.ENTRIES(BHT_ENTRIES), .CTR_BITS(CTR_BITS), .IW(IW)) u_bht (
    .clk        (clk),
    .rd_idx_i   (bus.fetch_pc[IW+1:2]),
    .rd_msb_o   (rd_msb),
    .init_i     (!run),
    .init_idx_i (init_idx_q),
    .upd_i      (act && is_br && !bad_f3),
    .upd_idx_i  (bus.ex_pc[IW+1:2]),
    .upd_taken_i(br_taken)
  );
  assign bus.pred_taken  = run && rd_msb;
  assign bus.bru_ready   = run;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.illegal_br  = illegal_q;
`ifdef BRU_PERF_EN
  logic [31:0] perf_br_q, perf_mis_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_br_q  <= (act && ctrl && !(&perf_br_q)) ? perf_br_q + 32'd1 : perf_br_q;
      perf_mis_q <= (mispredict && !(&perf_mis_q)) ? perf_mis_q + 32'd1 : perf_mis_q;
    end
  end
  assign bus.perf_branches    = perf_br_q;
  assign bus.perf_mispredicts = perf_mis_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  branch_resolve_unit_if #(.XLEN(32)) bus ();
  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64), .CTR_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                    input logic [31:0] alu, input logic [31:0] tgt, input logic pr);
    bus.ex_valid      = 1'b1;
    bus.ex_opcode     = op;
    bus.ex_funct3     = f3;
    bus.ex_pc         = pc;
    bus.ex_alu_out    = alu;
    bus.ex_target     = tgt;
    bus.ex_pred_taken = pr;
  endtask
  task automatic idle;
    bus.ex_valid = 1'b0;
  endtask
  task automatic pred(input string tag, input logic [31:0] pc, input logic exp);
    bus.fetch_pc = pc;
    #1;
    check(tag, 32'(bus.pred_taken), 32'(exp));
  endtask
  initial begin
    bus.fetch_pc = 32'h100;
    ex(7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    idle;
    repeat (2) tick;
    check("rst_redirect", 32'(bus.redirect), 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst_illegal", 32'(bus.illegal_br), 32'd0);
    check("rst_ready", 32'(bus.bru_ready), 32'd0);
    pred("rst_pred", 32'h100, 1'b0);
    rst = 1'b0;
    check("init_ready_c0", 32'(bus.bru_ready), 32'd0);
    pred("init_pred", 32'hFC, 1'b0);
    repeat (63) tick;
    check("init_ready_c63", 32'(bus.bru_ready), 32'd0);
    tick;
    check("init_ready_c64", 32'(bus.bru_ready), 32'd1);
    pred("pred_weak_nt", 32'h100, 1'b0);
    // BEQ taken, predicted not taken
    ex(OP_BRANCH, F3_BEQ, 32'h100, 32'd0, 32'h140, 1'b0);
    tick;
    idle;
    check("beq_redirect", 32'(bus.redirect), 32'd1);
    check("beq_redirect_pc", bus.redirect_pc, 32'h140);
    pred("beq_trained", 32'h100, 1'b1);
    tick;
    check("redirect_pulse", 32'(bus.redirect), 32'd0);
    // back-to-back BNE taken, predicted taken: entry saturates
    ex(OP_BRANCH, F3_BNE, 32'h100, 32'd5, 32'h80, 1'b1);
    tick;
    check("bne1_redirect", 32'(bus.redirect), 32'd0);
    tick;
    idle;
    check("bne2_redirect", 32'(bus.redirect), 32'd0);
    pred("bne_saturate", 32'h100, 1'b1);
    // BLT not taken, predicted taken
    ex(OP_BRANCH, F3_BLT, 32'h200, 32'd0, 32'h280, 1'b1);
    tick;
    check("blt_redirect", 32'(bus.redirect), 32'd1);
    check("blt_redirect_pc", bus.redirect_pc, 32'h204);
    ex(OP_BRANCH, F3_BEQ, 32'h200, 32'd1, 32'h240, 1'b1);
    tick;
    idle;
    check("squash_redirect", 32'(bus.redirect), 32'd0);
    pred("squash_noupd", 32'h200, 1'b1);
    // JALR odd target, predicted not taken; must not train entry 2
    ex(OP_JALR, 3'd0, 32'h308, 32'd0, 32'h301, 1'b0);
    tick;
    idle;
    check("jalr_redirect", 32'(bus.redirect), 32'd1);
    check("jalr_redirect_pc", bus.redirect_pc, 32'h300);
    pred("jalr_notrain", 32'h308, 1'b0);
    tick;
    check("jalr_pulse", 32'(bus.redirect), 32'd0);
    // illegal funct3 010
    ex(OP_BRANCH, 3'b010, 32'h104, 32'd0, 32'h1C0, 1'b1);
    tick;
    idle;
    check("ill_flag", 32'(bus.illegal_br), 32'd1);
    check("ill_redirect", 32'(bus.redirect), 32'd0);
    pred("ill_noupd", 32'h104, 1'b0);
    tick;
    check("ill_pulse", 32'(bus.illegal_br), 32'd0);
    // JAL mispredict, then squashed illegal branch
    ex(OP_JAL, 3'd0, 32'h400, 32'd0, 32'h500, 1'b0);
    tick;
    check("jal_redirect", 32'(bus.redirect), 32'd1);
    check("jal_redirect_pc", bus.redirect_pc, 32'h500);
    ex(OP_BRANCH, 3'b011, 32'h404, 32'd0, 32'd0, 1'b1);
    tick;
    check("squash_ill_flag", 32'(bus.illegal_br), 32'd0);
    check("squash_ill_redirect", 32'(bus.redirect), 32'd0);
    ex(OP_JAL, 3'd0, 32'h410, 32'd0, 32'h600, 1'b1);
    tick;
    check("jal_hit", 32'(bus.redirect), 32'd0);
    ex(7'b0010011, 3'd0, 32'h414, 32'd0, 32'h700, 1'b1);
    tick;
    idle;
    check("nonctrl", 32'(bus.redirect), 32'd0);
    // BGE not taken at top of address space: pc+4 wraps to 0
    ex(OP_BRANCH, F3_BGE, 32'hFFFF_FFFC, 32'd1, 32'h10, 1'b1);
    tick;
    idle;
    check("wrap_redirect", 32'(bus.redirect), 32'd1);
    check("wrap_redirect_pc", bus.redirect_pc, 32'd0);
    pred("wrap_dec", 32'hFFFF_FFFC, 1'b0);
    tick;
    ex(OP_BRANCH, F3_BLTU, 32'h108, 32'd1, 32'h1000, 1'b0);
    tick;
    idle;
    check("bltu_redirect", 32'(bus.redirect), 32'd1);
    check("bltu_redirect_pc", bus.redirect_pc, 32'h1000);
    tick;
    // mispredict, then reset while the redirect is pending
    ex(OP_BRANCH, F3_BEQ, 32'h100, 32'd0, 32'h140, 1'b0);
    tick;
    idle;
    check("pre_rst_redirect", 32'(bus.redirect), 32'd1);
`ifdef BRU_PERF_EN
    check("perf_branches", bus.perf_branches, 32'd10);
    check("perf_mispredicts", bus.perf_mispredicts, 32'd7);
`endif
    rst = 1'b1;
    tick;
    check("rst2_redirect", 32'(bus.redirect), 32'd0);
    check("rst2_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst2_illegal", 32'(bus.illegal_br), 32'd0);
    check("rst2_ready", 32'(bus.bru_ready), 32'd0);
    pred("rst2_pred", 32'h100, 1'b0);
    rst = 1'b0;
    ex(OP_BRANCH, F3_BEQ, 32'h100, 32'd0, 32'h140, 1'b0);
    tick;
    idle;
    check("init_ignore", 32'(bus.redirect), 32'd0);
    check("init_ignore_pc", bus.redirect_pc, 32'd0);
`ifdef BRU_PERF_EN
    check("perf_branches_rst", bus.perf_branches, 32'd0);
    check("perf_mispredicts_rst", bus.perf_mispredicts, 32'd0);
`endif
    repeat (62) tick;
    check("reinit_ready_c63", 32'(bus.bru_ready), 32'd0);
    tick;
    check("reinit_ready_c64", 32'(bus.bru_ready), 32'd1);
    pred("reinit_pred0", 32'h100, 1'b0);
    pred("reinit_pred1", 32'h104, 1'b0);
    ex(OP_BRANCH, F3_BEQ, 32'h100, 32'd0, 32'h140, 1'b1);
    tick;
    idle;
    check("reinit_hit", 32'(bus.redirect), 32'd0);
    pred("reinit_weak", 32'h100, 1'b1);
    tick;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
